// File: rtl/imem_boot_loader.sv
// Boot loader: receives a byte-stream program image, writes 32-bit little-endian words
// into instruction memory, checks the trailing XOR checksum and gates the core reset.
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_reset,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic [2:0]            dbg_state
);

  // Handshake: a byte moves only on a rising edge where in_valid && in_ready;
  // in_ready depends on the state alone, never on in_valid.
  typedef enum logic [2:0] {
    S_HDR0  = 3'd0,
    S_HDR1  = 3'd1,
    S_LOAD  = 3'd2,
    S_CSUM  = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

  state_t                state_q, state_d;
  logic [15:0]           count_q, count_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [7:0]            xor_q, xor_d;
  logic [23:0]           asm_q, asm_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
  logic [ADDR_WIDTH:0]   word_inc;
  logic                  accept;

  assign in_ready = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                    (state_q == S_LOAD) || (state_q == S_CSUM);
  assign accept   = in_valid && in_ready;
  assign word_inc = word_count_q + {{ADDR_WIDTH{1'b0}}, 1'b1};

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    byte_cnt_d   = byte_cnt_q;
    xor_d        = xor_q;
    asm_d        = asm_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    word_count_d = word_count_q;
    case (state_q)
      S_HDR0: begin
        if (accept) begin
          count_d[7:0] = in_data;
          state_d      = S_HDR1;
        end
      end
      S_HDR1: begin
        if (accept) begin
          count_d[15:8] = in_data;
          if ((count_d == 16'd0) || (count_d > MAX_N)) state_d = S_ERROR;
          else                                          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          xor_d      = xor_q ^ in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: asm_d[7:0]   = in_data;
            2'd1: asm_d[15:8]  = in_data;
            2'd2: asm_d[23:16] = in_data;
            default: begin
              // Fourth byte completes the word; the address is the pre-increment count.
              we_d         = 1'b1;
              addr_d       = word_count_q[ADDR_WIDTH-1:0];
              wdata_d      = {in_data, asm_q};
              word_count_d = word_inc;
              if (16'(word_inc) == count_q) state_d = S_CSUM;
            end
          endcase
        end
      end
      S_CSUM: begin
        if (accept) begin
          if (in_data == xor_q) state_d = S_DONE;
          else                  state_d = S_ERROR;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_HDR0;
      count_q      <= '0;
      byte_cnt_q   <= '0;
      xor_q        <= '0;
      asm_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      byte_cnt_q   <= byte_cnt_d;
      xor_q        <= xor_d;
      asm_q        <= asm_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      word_count_q <= word_count_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign word_count = word_count_q;
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERROR);
  assign core_reset = (state_q != S_DONE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: byte streams are parsed by a stream-level
// model to produce expected writes and final status, then compared against the DUT.
module tb_imem_boot_loader;

  localparam int AW   = 8;
  localparam int MAXW = 256;
  localparam int W    = AW + 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready, imem_we, core_reset, done, error;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   word_count;
  logic [2:0]    dbg_state;

  imem_boot_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MAXW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_reset(core_reset), .done(done),
    .error(error), .word_count(word_count), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Scoreboard state
  logic [W-1:0]  exp_q[$];
  logic [7:0]    stream_q[$];
  logic          we_expect = 1'b0;
  logic          mon_en = 1'b0;
  logic [AW-1:0] hold_addr = '0;
  logic [31:0]   hold_data = '0;

  always @(negedge clock) begin
    if (mon_en) begin
      checks++;
      if (imem_we !== we_expect) begin
        errors++;
        $display("FAIL we_timing t=%0t got=%0b exp=%0b", $time, imem_we, we_expect);
      end
      if (imem_we === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write got addr=%0d data=%08h exp none", imem_addr, imem_wdata);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          if ({imem_addr, imem_wdata} !== e) begin
            errors++;
            $display("FAIL write got addr=%0d data=%08h exp addr=%0d data=%08h",
                     imem_addr, imem_wdata, e[W-1:32], e[31:0]);
          end
        end
        hold_addr = imem_addr;
        hold_data = imem_wdata;
      end else begin
        checks++;
        if (imem_addr !== hold_addr || imem_wdata !== hold_data) begin
          errors++;
          $display("FAIL hold got addr=%0d data=%08h exp addr=%0d data=%08h",
                   imem_addr, imem_wdata, hold_addr, hold_data);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  // Reference model: parse the stream at the format level.
  task automatic model_expect(output logic exp_done, output logic exp_err, output int exp_words);
    int n;
    logic [7:0]  x;
    logic [31:0] w;
    n = int'({stream_q[1], stream_q[0]});
    exp_q.delete();
    if (n == 0 || n > MAXW) begin
      exp_done = 1'b0; exp_err = 1'b1; exp_words = 0;
    end else begin
      x = 8'h00;
      for (int i = 0; i < n; i++) begin
        w = {stream_q[2+4*i+3], stream_q[2+4*i+2], stream_q[2+4*i+1], stream_q[2+4*i]};
        x = x ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
        exp_q.push_back({AW'(i), w});
      end
      exp_done  = (stream_q[2+4*n] == x);
      exp_err   = !exp_done;
      exp_words = n;
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    we_expect = 1'b0;
    @(negedge clock);
  endtask

  task automatic reset_dut();
    @(negedge clock);
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    @(posedge clock);
    we_expect = 1'b0; hold_addr = '0; hold_data = '0;
    @(negedge clock);
    reset = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic send_range(input int gap_max, input int lo, input int hi);
    int n;
    logic ok;
    n = int'({stream_q[1], stream_q[0]});
    for (int j = lo; j < hi; j++) begin
      if (gap_max > 0 && j > 0) begin
        repeat ($urandom_range(1, gap_max)) begin
          in_valid = 1'b0; in_data = 8'hFF;
          tick();
        end
      end
      in_valid = 1'b1; in_data = stream_q[j];
      ok = 1'b0;
      for (int t = 0; t < 8 && !ok; t++) begin
        ok = in_ready;
        @(posedge clock);
        we_expect = ok && (j >= 2) && (j < 2 + 4*n) && (((j - 2) % 4) == 3);
        @(negedge clock);
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL handshake byte=%0d got in_ready=0 exp in_ready=1", j);
        break;
      end
    end
    in_valid = 1'b0; in_data = 8'h00;
  endtask

  task automatic load_nominal(input logic [7:0] csum);
    stream_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, csum};
  endtask

  // Tests
  task automatic test_reset();
    reset_dut();
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%0b exp=1", in_ready); end
    checks++; if (imem_we !== 1'b0 || imem_addr !== '0 || imem_wdata !== '0) begin
      errors++; $display("FAIL rst_imem got we=%0b a=%0d d=%08h exp 0", imem_we, imem_addr, imem_wdata); end
    checks++; if ({core_reset, done, error} !== 3'b100) begin
      errors++; $display("FAIL rst_status got=%03b exp=100", {core_reset, done, error}); end
    checks++; if (word_count !== '0) begin errors++; $display("FAIL rst_wc got=%0d exp=0", word_count); end
  endtask

  task automatic test_nominal();
    logic ed, ee; int ew;
    reset_dut();
    load_nominal(8'hD0);
    model_expect(ed, ee, ew);
    checks++; if (exp_q.size() != 2 || exp_q[0][31:0] != 32'h00000013 || exp_q[1][31:0] != 32'h00500093) begin
      errors++; $display("FAIL nominal_model got=%0d words exp=2", exp_q.size()); end
    send_range(0, 0, 10);
    checks++; if (done !== 1'b0 || core_reset !== 1'b1) begin
      errors++; $display("FAIL nominal_pre got done=%0b cr=%0b exp done=0 cr=1", done, core_reset); end
    send_range(0, 10, 11);
    checks++; if (done !== ed || core_reset !== 1'b0 || error !== ee) begin
      errors++; $display("FAIL nominal_done got d=%0b cr=%0b e=%0b exp d=%0b cr=0 e=%0b", done, core_reset, error, ed, ee); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL nominal_ready got=%0b exp=0", in_ready); end
    repeat (3) tick();
    checks++; if (word_count !== (AW+1)'(ew) || exp_q.size() != 0) begin
      errors++; $display("FAIL nominal_wc got=%0d pend=%0d exp=%0d pend=0", word_count, exp_q.size(), ew); end
  endtask

  task automatic test_bad_header(input logic [7:0] lo, input logic [7:0] hi);
    logic ed, ee; int ew;
    reset_dut();
    stream_q = '{lo, hi};
    model_expect(ed, ee, ew);
    send_range(0, 0, 2);
    checks++; if (error !== ee || done !== ed || core_reset !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL hdr_%02h%02h got e=%0b d=%0b cr=%0b rdy=%0b exp e=1 d=0 cr=1 rdy=0",
                         hi, lo, error, done, core_reset, in_ready); end
    repeat (3) tick();
    checks++; if (word_count !== '0 || error !== 1'b1) begin
      errors++; $display("FAIL hdr_sticky got wc=%0d e=%0b exp wc=0 e=1", word_count, error); end
  endtask

  task automatic test_max_load();
    logic ed, ee; int ew;
    logic [7:0] x;
    reset_dut();
    stream_q = '{8'h00, 8'h01};
    x = 8'h00;
    for (int i = 0; i < 4*MAXW; i++) begin
      stream_q.push_back(8'($urandom_range(0, 255)));
      x ^= stream_q[$];
    end
    stream_q.push_back(x);
    model_expect(ed, ee, ew);
    checks++; if (exp_q[$][W-1:32] != AW'(MAXW-1)) begin
      errors++; $display("FAIL max_model got addr=%0d exp=%0d", exp_q[$][W-1:32], MAXW-1); end
    send_range(0, 0, stream_q.size());
    checks++; if (done !== 1'b1 || error !== 1'b0 || core_reset !== 1'b0) begin
      errors++; $display("FAIL max_done got d=%0b e=%0b cr=%0b exp d=1 e=0 cr=0", done, error, core_reset); end
    checks++; if (imem_addr !== AW'(MAXW-1)) begin
      errors++; $display("FAIL max_last_addr got=%0d exp=%0d", imem_addr, MAXW-1); end
    repeat (2) tick();
    checks++; if (word_count !== (AW+1)'(MAXW) || exp_q.size() != 0) begin
      errors++; $display("FAIL max_wc got=%0d pend=%0d exp=%0d pend=0", word_count, exp_q.size(), MAXW); end
  endtask

  task automatic test_bad_csum();
    logic ed, ee; int ew;
    reset_dut();
    load_nominal(8'hD1);
    model_expect(ed, ee, ew);
    send_range(0, 0, 11);
    checks++; if (error !== ee || done !== ed || core_reset !== 1'b1) begin
      errors++; $display("FAIL csum_bad got e=%0b d=%0b cr=%0b exp e=%0b d=%0b cr=1", error, done, core_reset, ee, ed); end
    repeat (3) tick();
    checks++; if (word_count !== (AW+1)'(2) || exp_q.size() != 0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL csum_bad_writes got wc=%0d pend=%0d rdy=%0b exp wc=2 pend=0 rdy=0",
                         word_count, exp_q.size(), in_ready); end
  endtask

  task automatic test_gapped();
    logic ed, ee; int ew;
    reset_dut();
    load_nominal(8'hD0);
    model_expect(ed, ee, ew);
    send_range(3, 0, 11);
    checks++; if (done !== ed || error !== ee || core_reset !== 1'b0) begin
      errors++; $display("FAIL gapped got d=%0b e=%0b cr=%0b exp d=%0b e=%0b cr=0", done, error, core_reset, ed, ee); end
    repeat (2) tick();
    checks++; if (word_count !== (AW+1)'(ew) || exp_q.size() != 0) begin
      errors++; $display("FAIL gapped_wc got=%0d pend=%0d exp=%0d", word_count, exp_q.size(), ew); end
  endtask

  task automatic test_reset_mid();
    logic ed, ee; int ew;
    reset_dut();
    load_nominal(8'hD0);
    model_expect(ed, ee, ew);
    send_range(0, 0, 5);
    reset_dut();
    checks++; if (dbg_state !== 3'd0 || in_ready !== 1'b1 || word_count !== '0 || core_reset !== 1'b1) begin
      errors++; $display("FAIL mid_reset got st=%0d rdy=%0b wc=%0d cr=%0b exp st=0 rdy=1 wc=0 cr=1",
                         dbg_state, in_ready, word_count, core_reset); end
    model_expect(ed, ee, ew);
    send_range(0, 0, 11);
    checks++; if (done !== 1'b1 || error !== 1'b0) begin
      errors++; $display("FAIL mid_replay got d=%0b e=%0b exp d=1 e=0", done, error); end
    repeat (2) tick();
    checks++; if (word_count !== (AW+1)'(2) || exp_q.size() != 0) begin
      errors++; $display("FAIL mid_replay_wc got=%0d pend=%0d exp=2", word_count, exp_q.size()); end
  endtask

  task automatic test_random();
    logic ed, ee; int ew; int n;
    logic [7:0] x;
    repeat (8) begin
      reset_dut();
      n = $urandom_range(1, 12);
      stream_q = '{8'(n), 8'h00};
      x = 8'h00;
      for (int i = 0; i < 4*n; i++) begin
        stream_q.push_back(8'($urandom_range(0, 255)));
        x ^= stream_q[$];
      end
      if ($urandom_range(0, 3) == 0) x ^= 8'($urandom_range(1, 255));
      stream_q.push_back(x);
      model_expect(ed, ee, ew);
      send_range($urandom_range(0, 3), 0, stream_q.size());
      checks++; if (done !== ed || error !== ee || core_reset !== !ed) begin
        errors++; $display("FAIL rand_n%0d got d=%0b e=%0b cr=%0b exp d=%0b e=%0b", n, done, error, core_reset, ed, ee); end
      repeat (2) tick();
      checks++; if (word_count !== (AW+1)'(ew) || exp_q.size() != 0) begin
        errors++; $display("FAIL rand_wc got=%0d pend=%0d exp=%0d", word_count, exp_q.size(), ew); end
    end
  endtask

  initial begin
    repeat (2) @(posedge clock);
    test_reset();
    test_nominal();
    test_bad_header(8'h00, 8'h00);
    test_bad_header(8'h01, 8'h01);
    test_max_load();
    test_bad_csum();
    test_gapped();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream stage of the single-cycle Processor.
- Receives a program image as a byte stream over a valid/ready handshake.
- Assembles the bytes into 32-bit little-endian instruction words, writes them into instruction memory, and verifies a trailing XOR checksum.
- Holds the Processor in reset until the image has loaded and verified cleanly.

Parameters:
- ADDR_WIDTH, 8, instruction-memory word-address width.
- MAX_WORDS, 256, largest legal image size in words; must be ≤ 2**ADDR_WIDTH.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  a byte is present on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  instruction-memory write strobe, one cycle wide.
- imem_addr  output  ADDR_WIDTH  word address of the write.
- imem_wdata  output  32  word being written.
- core_reset  output  1  active-high reset hold for the Processor.
- done  output  1  image loaded and checksum matched; sticky.
- error  output  1  header or checksum failure; sticky.
- word_count  output  ADDR_WIDTH+1  number of words written so far.

Behaviour:
- Handshake: a byte is accepted only when in_valid and in_ready are both 1 on a rising edge. Cycles with in_valid=0 are ignored. in_data is don't-care when in_valid=0.
- Stream format, in order:
  - count low byte, then count high byte (16-bit word count N);
  - 4·N payload bytes, little-endian per word (byte k of a word maps to bits [8k+7:8k]);
  - one checksum byte, equal to the XOR of all payload bytes (the header is not included).
- FSM states: HDR0, HDR1, LOAD, CSUM, DONE, ERROR.
  - HDR0: accept a byte, latch count[7:0], go to HDR1.
  - HDR1: accept a byte, latch count[15:8]. If N==0 or N>MAX_WORDS, go to ERROR; else go to LOAD.
  - LOAD: accept bytes into the assembly register. A 2-bit byte counter tracks position within the word, and a running XOR accumulates every payload byte. When the 4th byte of the word is accepted, the write is issued. After the 4th byte of word N−1, go to CSUM.
  - CSUM: accept one byte. If it equals the running XOR, go to DONE; else go to ERROR.
  - DONE and ERROR are terminal until reset.
- in_ready is 1 in HDR0, HDR1, LOAD and CSUM; it is 0 in DONE and ERROR.
- Write timing: imem_we, imem_addr and imem_wdata are registered. imem_we=1 for exactly one cycle, in the cycle after the handshake of a word's 4th byte. imem_addr equals the word index, starting at 0. word_count increments in the same cycle imem_we is asserted.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- Termination timing: done=1 and core_reset=0 in the cycle after a matching checksum byte is accepted. error=1 in the cycle after the failing HDR1 or CSUM byte is accepted.
- In ERROR: core_reset stays 1, done=0, and no further writes occur. Words already written are not rolled back.
- Reset values, in the cycle after reset is sampled high:
  - state=HDR0, in_ready=1;
  - imem_we=0, imem_addr=0, imem_wdata=0;
  - core_reset=1, done=0, error=0, word_count=0;
  - byte counter, XOR accumulator and count register all 0.
- Reset mid-operation: the same values apply. A partially assembled word is discarded, and memory contents are untouched.
- Boundary: N==MAX_WORDS is legal; the last write goes to address MAX_WORDS−1. The address never wraps.

Test Plan:
1. Nominal load:
   - Stimulus: bytes 02 00 | 13 00 00 00 | 93 00 50 00 | D0, back-to-back.
   - Response: a write of addr0=0x00000013, then a write of addr1=0x00500093; word_count=2; done=1 and core_reset=0 one cycle after the D0 byte; in_ready=0 thereafter.
2. Zero-size header:
   - Stimulus: 00 00.
   - Response: error=1 one cycle after the 2nd byte; in_ready=0; no imem_we; core_reset=1.
3. Oversize header:
   - Stimulus: 01 01 (N=257) with MAX_WORDS=256.
   - Response: error=1 and no writes. Also load N=256 (00 01) with a correct checksum: last write is at addr 255, done=1.
4. Bad checksum:
   - Stimulus: scenario 1 with the final byte D1.
   - Response: both writes still occur; error=1; done=0; core_reset=1.
5. Gapped stream:
   - Stimulus: scenario 1 with in_valid low for 1–3 random cycles between bytes; in_data driven with 0xFF while invalid.
   - Response: identical writes and identical final outputs.
6. Reset mid-load:
   - Stimulus: assert reset for one cycle after 5 bytes of scenario 1.
   - Response: next cycle shows state=HDR0, in_ready=1, word_count=0, core_reset=1. Replaying the full scenario 1 stream then reaches done=1.
